// File: rtl/decoder_output_collector_if.sv
// Result-stream interface between the decoder output FIFO and the collector.
// The FIFO side drives data/valid; the collector drives ready.
interface decoder_output_collector_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/decoder_output_collector.sv
// decoder_output_collector: consumes the decoder result stream frame by frame.
// Each frame is a header word (cycles in [15:0], iterations in [23:16]),
// zero or more body words, and a TERMINATOR word. Per-frame results and run
// statistics are published on a one-cycle frame_done pulse; a stalled stream
// aborts the frame after TIMEOUT_CYCLES idle cycles.
// Optional feature macro: COLLECTOR_MAX_TRACK_EN enables the max_cycles register.
module decoder_output_collector #(
    parameter logic [31:0] TERMINATOR     = 32'hffffffff,
    parameter int          MSG_CNT_WIDTH  = 16,
    parameter int          STAT_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    decoder_output_collector_if.slave    stream,
    input  logic                         arm,
    output logic                         busy,
    output logic                         frame_done,
    output logic [15:0]                  frame_cycles,
    output logic [7:0]                   frame_iterations,
    output logic [MSG_CNT_WIDTH-1:0]     frame_msg_count,
    output logic [STAT_WIDTH-1:0]        frame_count,
    output logic [STAT_WIDTH-1:0]        total_cycles,
    output logic [15:0]                  max_cycles,
    output logic                         bad_frame,
    output logic                         timeout_err
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        BODY,
        DONE
    } state_t;

    state_t                   state;
    logic [IDLE_W-1:0]        idle_cnt;
    logic [MSG_CNT_WIDTH-1:0] msg_cnt;
    logic [15:0]              hdr_cycles;
    logic [7:0]               hdr_iterations;

    logic                     handshake;
    logic                     is_term;
    logic [STAT_WIDTH:0]      total_sum;

    // in_ready depends on state alone so the FIFO never sees a loop through valid.
    assign stream.in_ready = (state == HEADER) || (state == BODY);
    assign busy            = (state != IDLE);
    assign handshake       = stream.in_valid && stream.in_ready;
    assign is_term         = (stream.in_data == TERMINATOR);

    // One extra bit catches the carry used for saturation.
    assign total_sum = {1'b0, total_cycles} + (STAT_WIDTH + 1)'(hdr_cycles);

    // Frame FSM: header capture, body counting, idle timeout and stat update.
    // Header values are held privately so frame_* only change at a completed frame.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state            <= IDLE;
            idle_cnt         <= '0;
            msg_cnt          <= '0;
            hdr_cycles       <= '0;
            hdr_iterations   <= '0;
            frame_done       <= 1'b0;
            frame_cycles     <= '0;
            frame_iterations <= '0;
            frame_msg_count  <= '0;
            frame_count      <= '0;
            total_cycles     <= '0;
            bad_frame        <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        idle_cnt <= '0;
                        state    <= HEADER;
                    end
                end

                HEADER, BODY: begin
                    if (handshake) begin
                        idle_cnt <= '0;
                        if (state == HEADER) begin
                            if (is_term) begin
                                // Empty frame: report zeros and flag it; totals gain nothing.
                                bad_frame        <= 1'b1;
                                frame_cycles     <= '0;
                                frame_iterations <= '0;
                                frame_msg_count  <= '0;
                                frame_count      <= frame_count + STAT_WIDTH'(1);
                                frame_done       <= 1'b1;
                                state            <= DONE;
                            end else begin
                                hdr_cycles     <= stream.in_data[15:0];
                                hdr_iterations <= stream.in_data[23:16];
                                msg_cnt        <= '0;
                                state          <= BODY;
                            end
                        end else if (is_term) begin
                            frame_cycles     <= hdr_cycles;
                            frame_iterations <= hdr_iterations;
                            frame_msg_count  <= msg_cnt;
                            frame_count      <= frame_count + STAT_WIDTH'(1);
                            total_cycles     <= total_sum[STAT_WIDTH] ? '1
                                                : total_sum[STAT_WIDTH-1:0];
                            frame_done       <= 1'b1;
                            state            <= DONE;
                        end else if (msg_cnt != '1) begin
                            msg_cnt <= msg_cnt + MSG_CNT_WIDTH'(1);
                        end
                    end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        // Stream stalled: abandon the frame without touching stats.
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef COLLECTOR_MAX_TRACK_EN
    logic body_term;

    assign body_term = handshake && is_term && (state == BODY);

    // Track the largest frame_cycles; an empty frame contributes 0 and never wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_cycles <= '0;
        end else if (body_term && (hdr_cycles > max_cycles)) begin
            max_cycles <= hdr_cycles;
        end
    end
`else
    assign max_cycles = 16'h0;
`endif

endmodule

// File: tb/tb_decoder_output_collector.sv
// Directed self-checking bench for decoder_output_collector.
// Inputs change and outputs are sampled on the falling clock edge.
// Honours COLLECTOR_MAX_TRACK_EN for the expected max_cycles value.
module tb_decoder_output_collector;

    localparam int          TMO  = 16;
    localparam logic [31:0] TERM = 32'hffffffff;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cycles;
    logic [7:0]  frame_iterations;
    logic [15:0] frame_msg_count;
    logic [31:0] frame_count;
    logic [31:0] total_cycles;
    logic [15:0] max_cycles;
    logic        bad_frame;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    decoder_output_collector_if stream_if ();

    decoder_output_collector #(
        .TERMINATOR     (TERM),
        .MSG_CNT_WIDTH  (16),
        .STAT_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stream           (stream_if),
        .arm              (arm),
        .busy             (busy),
        .frame_done       (frame_done),
        .frame_cycles     (frame_cycles),
        .frame_iterations (frame_iterations),
        .frame_msg_count  (frame_msg_count),
        .frame_count      (frame_count),
        .total_cycles     (total_cycles),
        .max_cycles       (max_cycles),
        .bad_frame        (bad_frame),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_max(input logic [31:0] v);
`ifdef COLLECTOR_MAX_TRACK_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Offer one word for a single cycle; it is taken whenever the collector is ready.
    task automatic send_word(input logic [31:0] w);
        stream_if.in_data  = w;
        stream_if.in_valid = 1'b1;
        @(negedge clk);
        stream_if.in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(busy), 32'h0);
        check({tag, "_done"},   32'(frame_done), 32'h0);
        check({tag, "_cyc"},    32'(frame_cycles), 32'h0);
        check({tag, "_iter"},   32'(frame_iterations), 32'h0);
        check({tag, "_msg"},    32'(frame_msg_count), 32'h0);
        check({tag, "_fcnt"},   frame_count, 32'h0);
        check({tag, "_total"},  total_cycles, 32'h0);
        check({tag, "_max"},    32'(max_cycles), 32'h0);
        check({tag, "_bad"},    32'(bad_frame), 32'h0);
        check({tag, "_tmo"},    32'(timeout_err), 32'h0);
        check({tag, "_ready"},  32'(stream_if.in_ready), 32'h0);
    endtask

    // Watchdog: the directed sequence is short and fixed-length.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        arm                = 1'b0;
        stream_if.in_data  = 32'h0;
        stream_if.in_valid = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic frame: header, two body words, terminator.
        arm_pulse();
        check("f1_busy_hdr", 32'(busy), 32'h1);
        check("f1_ready_hdr", 32'(stream_if.in_ready), 32'h1);
        send_word(32'h0003_0041);
        send_word(32'h0000_0102);
        send_word(32'h0001_0203);
        check("f1_no_early_done", 32'(frame_done), 32'h0);
        check("f1_cyc_held", 32'(frame_cycles), 32'h0);
        send_word(TERM);
        check("f1_done", 32'(frame_done), 32'h1);
        check("f1_busy_done", 32'(busy), 32'h1);
        check("f1_cyc", 32'(frame_cycles), 32'h41);
        check("f1_iter", 32'(frame_iterations), 32'h3);
        check("f1_msg", 32'(frame_msg_count), 32'h2);
        check("f1_fcnt", frame_count, 32'h1);
        check("f1_total", total_cycles, 32'h41);
        check("f1_max", 32'(max_cycles), exp_max(32'h41));
        @(negedge clk);
        check("f1_done_pulse", 32'(frame_done), 32'h0);
        check("f1_idle", 32'(busy), 32'h0);
        check("f1_cyc_hold", 32'(frame_cycles), 32'h41);

        // Fresh run: two frames, accumulate and track max.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        arm_pulse();
        send_word(32'h0000_0010);
        send_word(TERM);
        check("f2_fcnt", frame_count, 32'h1);
        @(negedge clk);
        arm_pulse();
        send_word(32'h0002_0030);
        send_word(32'h1234_5678);
        send_word(TERM);
        check("f3_done", 32'(frame_done), 32'h1);
        check("f3_fcnt", frame_count, 32'h2);
        check("f3_total", total_cycles, 32'h40);
        check("f3_max", 32'(max_cycles), exp_max(32'h30));
        check("f3_iter", 32'(frame_iterations), 32'h2);
        check("f3_msg", 32'(frame_msg_count), 32'h1);
        @(negedge clk);

        // Valid while IDLE and unarmed: nothing is consumed.
        stream_if.in_data  = 32'h0005_0077;
        stream_if.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(stream_if.in_ready), 32'h0);
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_done", 32'(frame_done), 32'h0);
        end
        stream_if.in_valid = 1'b0;
        check("idle_fcnt", frame_count, 32'h2);
        check("idle_cyc", 32'(frame_cycles), 32'h30);

        // Terminator as header word: empty, flagged frame.
        arm_pulse();
        send_word(TERM);
        check("bad_done", 32'(frame_done), 32'h1);
        check("bad_flag", 32'(bad_frame), 32'h1);
        check("bad_cyc", 32'(frame_cycles), 32'h0);
        check("bad_iter", 32'(frame_iterations), 32'h0);
        check("bad_msg", 32'(frame_msg_count), 32'h0);
        check("bad_fcnt", frame_count, 32'h3);
        check("bad_total", total_cycles, 32'h40);
        check("bad_max", 32'(max_cycles), exp_max(32'h30));
        @(negedge clk);
        check("bad_sticky", 32'(bad_frame), 32'h1);

        // Longest tolerated bubbles (TMO-1 idle cycles) before every word.
        arm_pulse();
        repeat (TMO - 1) @(negedge clk);
        check("bub_busy_hdr", 32'(busy), 32'h1);
        send_word(32'h0002_0005);
        repeat (TMO - 1) @(negedge clk);
        send_word(32'hAAAA_5555);
        repeat (TMO - 1) @(negedge clk);
        send_word(TERM);
        check("bub_done", 32'(frame_done), 32'h1);
        check("bub_tmo", 32'(timeout_err), 32'h0);
        check("bub_cyc", 32'(frame_cycles), 32'h5);
        check("bub_msg", 32'(frame_msg_count), 32'h1);
        check("bub_fcnt", frame_count, 32'h4);
        check("bub_total", total_cycles, 32'h45);
        @(negedge clk);

        // Stall after arm: abort after exactly TMO idle cycles.
        arm_pulse();
        repeat (TMO - 1) @(negedge clk);
        check("tmo_busy_edge", 32'(busy), 32'h1);
        check("tmo_flag_edge", 32'(timeout_err), 32'h0);
        @(negedge clk);
        check("tmo_busy", 32'(busy), 32'h0);
        check("tmo_flag", 32'(timeout_err), 32'h1);
        check("tmo_done", 32'(frame_done), 32'h0);
        check("tmo_fcnt", frame_count, 32'h4);
        check("tmo_total", total_cycles, 32'h45);
        @(negedge clk);

        // Reset mid-frame clears everything without waiting for a clock edge.
        arm_pulse();
        send_word(32'h0001_0007);
        check("mid_busy", 32'(busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        arm_pulse();
        send_word(32'h0004_0009);
        send_word(TERM);
        check("post_done", 32'(frame_done), 32'h1);
        check("post_fcnt", frame_count, 32'h1);
        check("post_total", total_cycles, 32'h9);
        check("post_iter", 32'(frame_iterations), 32'h4);
        check("post_max", 32'(max_cycles), exp_max(32'h9));
        @(negedge clk);
        check("post_idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
